// File: rtl/ls_arb_pkg.sv
// Shared types and constants for the two-master load/store request arbiter.
package ls_arb_pkg;

  localparam int NUM_MASTERS    = 2;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  typedef logic [0:0] master_id_t;

  typedef struct packed {
    logic                      wr;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } ls_req_t;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Round-robin successor of a master index.
  function automatic master_id_t next_master(master_id_t id);
    return id + 1'b1;
  endfunction

endpackage

// File: rtl/ls_req_arbiter_if.sv
// Bundle of master-side and subsystem-side handshake signals around the arbiter.
// slave  : the arbiter's view
// master : the environment's view (masters plus load/store subsystem)
interface ls_req_arbiter_if
  import ls_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [NUM_MASTERS-1:0]            m_req_valid;
  logic [NUM_MASTERS-1:0]            m_req_ready;
  logic [NUM_MASTERS-1:0]            m_req_wr;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_req_addr;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_req_wdata;
  logic [NUM_MASTERS-1:0]            m_resp_valid;
  logic [NUM_MASTERS-1:0]            m_resp_ready;
  logic [DATA_WIDTH-1:0]             m_resp_rdata;
  logic                              m_resp_error;
  logic                              s_req_valid;
  logic                              s_req_ready;
  logic                              s_req_wr;
  logic [ADDR_WIDTH-1:0]             s_req_addr;
  logic [DATA_WIDTH-1:0]             s_req_wdata;
  logic                              s_resp_valid;
  logic                              s_resp_ready;
  logic [DATA_WIDTH-1:0]             s_resp_rdata;
  logic                              s_resp_error;
  logic                              orphan_err;

  modport slave (
    input  m_req_valid, m_req_wr, m_req_addr, m_req_wdata, m_resp_ready,
    input  s_req_ready, s_resp_valid, s_resp_rdata, s_resp_error,
    output m_req_ready, m_resp_valid, m_resp_rdata, m_resp_error,
    output s_req_valid, s_req_wr, s_req_addr, s_req_wdata, s_resp_ready,
    output orphan_err
  );

  modport master (
    output m_req_valid, m_req_wr, m_req_addr, m_req_wdata, m_resp_ready,
    output s_req_ready, s_resp_valid, s_resp_rdata, s_resp_error,
    input  m_req_ready, m_resp_valid, m_resp_rdata, m_resp_error,
    input  s_req_valid, s_req_wr, s_req_addr, s_req_wdata, s_resp_ready,
    input  orphan_err
  );
endinterface

// File: rtl/ls_tag_fifo.sv
// Small synchronous FIFO holding the issuing-master tag of each outstanding request.
module ls_tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer/count update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/ls_req_arbiter.sv
// Two-master round-robin arbiter in front of the load/store subsystem.
// Zero added latency on request and response paths; responses are steered
// back using the in-order tag FIFO.
//
// state      | meaning
// ARB_OPEN   | grant chosen round-robin from rr_ptr each cycle
// ARB_LOCKED | a request is stalled downstream; grant held at lock_idx
module ls_req_arbiter
  import ls_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic             clk,
  input logic             rst_n,
  ls_req_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  arb_state_t state_q, state_d;
  master_id_t lock_idx_q, lock_idx_d;
  master_id_t rr_ptr_q, rr_ptr_d;
  logic       orphan_q, orphan_d;

  master_id_t             grant;
  logic                   has_grant;
  logic                   can_issue;
  logic                   req_fire;
  logic                   tag_push;
  logic                   tag_pop;
  master_id_t             head_tag;
  logic [CNT_W-1:0]       tag_count;
  logic                   tag_full;
  logic                   tag_empty;
  logic [NUM_MASTERS-1:0] req_ready;
  logic [NUM_MASTERS-1:0] resp_valid;
  logic                   resp_ready;

  // A pop in the same cycle never makes room for a push.
  assign can_issue = (tag_count < CNT_W'(MAX_OUTSTANDING));

  // Grant selection: held master while locked, else first valid from rr_ptr.
  always_comb begin
    has_grant = 1'b0;
    grant     = rr_ptr_q;
    if (state_q == ARB_LOCKED) begin
      has_grant = 1'b1;
      grant     = lock_idx_q;
    end else if (bus.m_req_valid[rr_ptr_q]) begin
      has_grant = 1'b1;
      grant     = rr_ptr_q;
    end else if (bus.m_req_valid[next_master(rr_ptr_q)]) begin
      has_grant = 1'b1;
      grant     = next_master(rr_ptr_q);
    end
  end

  assign bus.s_req_valid = has_grant & can_issue & bus.m_req_valid[grant];
  assign bus.s_req_wr    = has_grant & bus.m_req_wr[grant];
  assign bus.s_req_addr  = has_grant ? bus.m_req_addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign bus.s_req_wdata = has_grant ? bus.m_req_wdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign req_fire        = bus.s_req_valid & bus.s_req_ready;
  assign tag_push        = req_fire & ~tag_full;

  // Per-master accept goes only to the granted master.
  always_comb begin
    req_ready = '0;
    if (has_grant && can_issue && bus.s_req_ready) begin
      req_ready[grant] = 1'b1;
    end
  end
  assign bus.m_req_ready = req_ready;

  // Lock / round-robin next state.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    if (req_fire) begin
      state_d  = ARB_OPEN;
      rr_ptr_d = next_master(grant);
    end else if (bus.s_req_valid) begin
      state_d    = ARB_LOCKED;
      lock_idx_d = grant;
    end
  end

  // Response steering by head tag; with no tag, accept and flag as orphan.
  always_comb begin
    resp_valid = '0;
    resp_ready = 1'b1;
    tag_pop    = 1'b0;
    orphan_d   = orphan_q;
    if (!tag_empty) begin
      resp_valid[head_tag] = bus.s_resp_valid;
      resp_ready           = bus.m_resp_ready[head_tag];
      tag_pop              = bus.s_resp_valid & bus.m_resp_ready[head_tag];
    end else if (bus.s_resp_valid) begin
      orphan_d = 1'b1;
    end
  end

  assign bus.m_resp_valid = resp_valid;
  assign bus.s_resp_ready = resp_ready;
  assign bus.m_resp_rdata = bus.s_resp_rdata;
  assign bus.m_resp_error = bus.s_resp_error;
  assign bus.orphan_err   = orphan_q;

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB_OPEN;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      orphan_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      orphan_q   <= orphan_d;
    end
  end

  ls_tag_fifo #(
    .WIDTH(1),
    .DEPTH(MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (tag_push),
    .wdata(grant),
    .pop  (tag_pop),
    .rdata(head_tag),
    .count(tag_count),
    .full (tag_full),
    .empty(tag_empty)
  );

endmodule

// File: tb/tb_ls_req_arbiter.sv
// Bench for ls_req_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue-based model.
module tb_ls_req_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ls_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ls_req_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: rotating priority, held grant on stall, queue of outstanding tags.
  bit          model_en = 1'b0;
  int          m_rr = 0;
  bit          m_lock = 1'b0;
  int          m_lock_idx = 0;
  bit          m_orphan = 1'b0;
  int          tagq[$];
  int          e_g;
  bit          e_hg, e_cani, e_srv, e_srr, was_empty;
  logic [1:0]  e_mrr, e_mrv;
  logic        e_wr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  always @(negedge clk) begin
    if (model_en) begin
      e_cani = (tagq.size() < MAXO);
      e_hg   = 1'b0;
      e_g    = 0;
      if (m_lock) begin
        e_hg = 1'b1;
        e_g  = m_lock_idx;
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (!e_hg && bus.m_req_valid[(m_rr + k) % 2]) begin
            e_hg = 1'b1;
            e_g  = (m_rr + k) % 2;
          end
        end
      end
      e_srv   = e_hg && e_cani && bus.m_req_valid[e_g];
      e_wr    = e_hg ? bus.m_req_wr[e_g] : 1'b0;
      e_addr  = e_hg ? bus.m_req_addr[e_g*AW +: AW] : '0;
      e_wdata = e_hg ? bus.m_req_wdata[e_g*DW +: DW] : '0;
      e_mrr   = (e_hg && e_cani && bus.s_req_ready) ? (2'b01 << e_g) : 2'b00;
      was_empty = (tagq.size() == 0);
      if (!was_empty) begin
        e_mrv = bus.s_resp_valid ? (2'b01 << tagq[0]) : 2'b00;
        e_srr = bus.m_resp_ready[tagq[0]];
      end else begin
        e_mrv = 2'b00;
        e_srr = 1'b1;
      end

      chk("s_req_valid",  bus.s_req_valid,  e_srv);
      chk("m_req_ready",  bus.m_req_ready,  e_mrr);
      chk("s_req_wr",     bus.s_req_wr,     e_wr);
      chk("s_req_addr",   bus.s_req_addr,   e_addr);
      chk("s_req_wdata",  bus.s_req_wdata,  e_wdata);
      chk("m_resp_valid", bus.m_resp_valid, e_mrv);
      chk("s_resp_ready", bus.s_resp_ready, e_srr);
      chk("m_resp_rdata", bus.m_resp_rdata, bus.s_resp_rdata);
      chk("m_resp_error", bus.m_resp_error, bus.s_resp_error);
      chk("orphan_err",   bus.orphan_err,   m_orphan);

      if (!rst_n) begin
        m_rr = 0; m_lock = 1'b0; m_lock_idx = 0; m_orphan = 1'b0;
        tagq.delete();
      end else begin
        if (!was_empty && bus.s_resp_valid && e_srr) void'(tagq.pop_front());
        if (was_empty && bus.s_resp_valid) m_orphan = 1'b1;
        if (e_srv && bus.s_req_ready) begin
          m_lock = 1'b0;
          m_rr   = (e_g + 1) % 2;
          tagq.push_back(e_g);
        end else if (e_srv) begin
          m_lock     = 1'b1;
          m_lock_idx = e_g;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.m_req_valid  = '0;
    bus.m_req_wr     = '0;
    bus.m_req_addr   = '0;
    bus.m_req_wdata  = '0;
    bus.m_resp_ready = '0;
    bus.s_req_ready  = 1'b0;
    bus.s_resp_valid = 1'b0;
    bus.s_resp_rdata = '0;
    bus.s_resp_error = 1'b0;
  endtask

  task automatic set_req(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                         input logic sready);
    bus.m_req_valid = v;
    bus.m_req_wr    = 2'b10;
    bus.m_req_addr  = {a1, a0};
    bus.m_req_wdata = {a1 ^ 32'h5555_0000, a0 ^ 32'h0000_AAAA};
    bus.s_req_ready = sready;
  endtask

  task automatic set_resp(input logic sv, input logic [1:0] mready, input logic [31:0] rd);
    bus.s_resp_valid = sv;
    bus.m_resp_ready = mready;
    bus.s_resp_rdata = rd;
    bus.s_resp_error = rd[0];
  endtask

  int pending;

  initial begin
    idle();
    rst_n = 1'b0;
    step();
    model_en = 1'b1;
    step();
    rst_n = 1'b1;
    #3;
    chk("rst_s_req_valid",  bus.s_req_valid,  1'b0);
    chk("rst_m_req_ready",  bus.m_req_ready,  2'b00);
    chk("rst_m_resp_valid", bus.m_resp_valid, 2'b00);
    chk("rst_s_resp_ready", bus.s_resp_ready, 1'b1);
    chk("rst_orphan",       bus.orphan_err,   1'b0);

    // 1: both masters valid, grants alternate; responses steer 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      step();
      set_req(2'b11, 32'h100, 32'h200, 1'b1);
      #3;
      chk("t1_grant", bus.m_req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("t1_addr",  bus.s_req_addr,  (i % 2 == 0) ? 32'h100 : 32'h200);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      idle();
      set_resp(1'b1, 2'b11, 32'h1000 + i);
      #3;
      chk("t1_resp_route", bus.m_resp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
    end

    // 2: master 1 stalled, master 0 joins; grant held at 1 until handshake
    step(); idle();
    set_req(2'b10, 32'h100, 32'h40, 1'b0);
    #3;
    chk("t2_addr_c0",  bus.s_req_addr,  32'h40);
    chk("t2_ready_c0", bus.m_req_ready, 2'b00);
    chk("t2_valid_c0", bus.s_req_valid, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      set_req(2'b11, 32'h100, 32'h40, 1'b0);
      #3;
      chk("t2_addr_held", bus.s_req_addr, 32'h40);
    end
    step();
    set_req(2'b11, 32'h100, 32'h40, 1'b1);
    #3;
    chk("t2_hs_grant", bus.m_req_ready, 2'b10);
    chk("t2_hs_addr",  bus.s_req_addr,  32'h40);
    step();
    set_req(2'b01, 32'h100, 32'h40, 1'b1);
    #3;
    chk("t2_next_m0",   bus.m_req_ready, 2'b01);
    chk("t2_next_addr", bus.s_req_addr,  32'h100);
    for (int i = 0; i < 2; i++) begin
      step(); idle();
      set_resp(1'b1, 2'b11, 32'h2000 + i);
      #3;
      chk("t2_resp_route", bus.m_resp_valid, (i == 0) ? 2'b10 : 2'b01);
    end

    // 3: fill to MAX_OUTSTANDING, same-cycle pop does not free a slot
    for (int i = 0; i < 4; i++) begin
      step(); idle();
      set_req(2'b01, 32'h3000 + i, 32'h0, 1'b1);
      #3;
      chk("t3_issue", bus.m_req_ready, 2'b01);
    end
    step();
    #3;
    chk("t3_full_ready", bus.m_req_ready, 2'b00);
    chk("t3_full_valid", bus.s_req_valid, 1'b0);
    step();
    set_resp(1'b1, 2'b01, 32'h33);
    #3;
    chk("t3_pop_blocks", bus.m_req_ready,  2'b00);
    chk("t3_pop_route",  bus.m_resp_valid, 2'b01);
    step();
    set_resp(1'b0, 2'b00, 32'h0);
    #3;
    chk("t3_reissue", bus.m_req_ready, 2'b01);
    for (int i = 0; i < 4; i++) begin
      step(); idle();
      set_resp(1'b1, 2'b01, 32'h3100 + i);
      #3;
      chk("t3_drain", bus.m_resp_valid, 2'b01);
    end

    // 4: master 1 response back-pressured for two cycles
    step(); idle();
    set_req(2'b10, 32'h0, 32'h44, 1'b1);
    #3;
    chk("t4_issue", bus.m_req_ready, 2'b10);
    for (int i = 0; i < 2; i++) begin
      step(); idle();
      set_resp(1'b1, 2'b00, 32'hDEADBEEF);
      #3;
      chk("t4_blocked", bus.s_resp_ready, 1'b0);
    end
    step();
    set_resp(1'b1, 2'b10, 32'hDEADBEEF);
    #3;
    chk("t4_mrv",   bus.m_resp_valid, 2'b10);
    chk("t4_rdata", bus.m_resp_rdata, 32'hDEADBEEF);
    chk("t4_srr",   bus.s_resp_ready, 1'b1);
    step();
    set_resp(1'b0, 2'b00, 32'h0);
    #3;
    chk("t4_popped_once", bus.s_resp_ready, 1'b1);

    // 5: orphan response when nothing is outstanding
    step();
    set_resp(1'b1, 2'b00, 32'h55);
    #3;
    chk("t5_srr",        bus.s_resp_ready, 1'b1);
    chk("t5_mrv",        bus.m_resp_valid, 2'b00);
    chk("t5_orphan_pre", bus.orphan_err,   1'b0);
    step();
    set_resp(1'b0, 2'b00, 32'h0);
    #3;
    chk("t5_orphan_set", bus.orphan_err, 1'b1);
    repeat (3) step();
    chk("t5_orphan_sticky", bus.orphan_err, 1'b1);

    // 6: reset with three tags outstanding and a locked grant
    for (int i = 0; i < 3; i++) begin
      step();
      set_req(2'b11, 32'h600, 32'h700, 1'b1);
    end
    step();
    set_req(2'b11, 32'h600, 32'h700, 1'b0);
    #3;
    chk("t6_lock_addr", bus.s_req_addr, 32'h700);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_req(2'b11, 32'h600, 32'h700, 1'b1);
    #3;
    chk("t6_first_m0",  bus.m_req_ready,  2'b01);
    chk("t6_orphan_clr", bus.orphan_err,  1'b0);
    chk("t6_no_tags",   bus.m_resp_valid, 2'b00);
    step(); idle();

    // Randomized traffic; the bench plays an in-order subsystem
    pending = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      rst_n            = ($urandom_range(299) != 0);
      bus.m_req_valid  = 2'($urandom);
      bus.m_req_wr     = 2'($urandom);
      bus.m_req_addr   = {$urandom, $urandom};
      bus.m_req_wdata  = {$urandom, $urandom};
      bus.s_req_ready  = ($urandom_range(3) != 0);
      bus.m_resp_ready = 2'($urandom);
      bus.s_resp_valid = (pending > 0) && ($urandom_range(1) == 1);
      bus.s_resp_rdata = $urandom;
      bus.s_resp_error = 1'($urandom);
      #3;
      if (!rst_n) begin
        pending = 0;
      end else begin
        if (bus.s_req_valid && bus.s_req_ready) pending++;
        if (bus.s_resp_valid && bus.s_resp_ready) pending--;
      end
    end
    rst_n = 1'b1;
    step(); idle();
    step();
    model_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
